// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants and state encodings for the PWM duty meter and its divider.
package pwm_meter_pkg;
  localparam int DUTY_SCALE = 1000;
  localparam int SCALE_W    = 10;   // bits needed to hold DUTY_SCALE
  localparam int DUTY_W     = 14;   // duty word width shared with the FND mux

  typedef enum logic {M_WAIT_FIRST, M_RUN} meas_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;
endpackage

// File: rtl/pwm_duty_meter_if.sv
// PWM input and measurement result bundle of the duty meter.
interface pwm_duty_meter_if;
  import pwm_meter_pkg::*;
  logic              i_pwm;
  logic [DUTY_W-1:0] o_duty;
  logic              o_valid;
  logic              o_stuck;
  logic              o_overrun;

  modport slave  (input i_pwm, output o_duty, o_valid, o_stuck, o_overrun);
  modport master (output i_pwm, input o_duty, o_valid, o_stuck, o_overrun);
endinterface

// File: rtl/pwm_duty_meter_seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, start/done handshake.
module pwm_seq_div import pwm_meter_pkg::*; #(
  parameter int N_W = 30,
  parameter int D_W = 20,
  parameter int Q_W = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quot
);
  localparam int CW = $clog2(N_W);

  div_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [D_W-1:0] rem, rem_n, dsr, dsr_n;
  logic [N_W-1:0] nq, nq_n;
  logic [D_W:0]   trial;
  logic           fits;

  // nq starts as the numerator and fills with quotient bits as it shifts out
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    dsr_n   = dsr;
    nq_n    = nq;
    trial   = {rem, nq[N_W-1]};
    fits    = (trial >= {1'b0, dsr});
    case (state)
      D_IDLE, D_DONE: begin
        if (start) begin
          state_n = D_RUN;
          cnt_n   = CW'(N_W - 1);
          rem_n   = '0;
          dsr_n   = den;
          nq_n    = num;
        end else begin
          state_n = D_IDLE;
        end
      end
      D_RUN: begin
        rem_n = fits ? D_W'(trial - {1'b0, dsr}) : D_W'(trial);
        nq_n  = {nq[N_W-2:0], fits};
        if (cnt == '0) state_n = D_DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= D_IDLE;
      cnt   <= '0;
      rem   <= '0;
      dsr   <= '0;
      nq    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      dsr   <= dsr_n;
      nq    <= nq_n;
    end
  end

  assign busy = (state == D_RUN);
  assign done = (state == D_DONE);
  assign quot = nq[Q_W-1:0];
endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: synchronizer, period/high counters, measurement FSM, permille divider.
module pwm_duty_meter import pwm_meter_pkg::*; #(
  parameter int CNT_W = 20
) (
  input  logic              sysclk,
  input  logic              i_rst,
  pwm_duty_meter_if.slave   bus
);
  localparam int               NUM_W   = CNT_W + SCALE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic pwm_s1, pwm_sync, pwm_prev, rise;

  always_ff @(posedge sysclk or posedge i_rst) begin
    if (i_rst) begin
      pwm_s1   <= 1'b0;
      pwm_sync <= 1'b0;
      pwm_prev <= 1'b0;
    end else begin
      pwm_s1   <= bus.i_pwm;
      pwm_sync <= pwm_s1;
      pwm_prev <= pwm_sync;
    end
  end

  assign rise = pwm_sync & ~pwm_prev;

  meas_state_t       m_state, m_state_n;
  logic [CNT_W-1:0]  period_cnt, period_n, high_cnt, high_n;
  logic [NUM_W-1:0]  num;
  logic [DUTY_W-1:0] div_quot, duty_hold, duty_n;
  logic              start, div_busy, div_done;
  logic              stuck_q, stuck_n, tmo_q, tmo_n, ovr_q, ovr_n;

  assign num = NUM_W'(high_cnt) * NUM_W'(DUTY_SCALE);

  // A rise always wins over the timeout; D_DONE counts as idle via div_busy.
  always_comb begin
    m_state_n = m_state;
    period_n  = period_cnt;
    high_n    = high_cnt;
    start     = 1'b0;
    ovr_n     = 1'b0;
    tmo_n     = 1'b0;
    stuck_n   = stuck_q;
    duty_n    = div_done ? div_quot : duty_hold;
    case (m_state)
      M_WAIT_FIRST: begin
        period_n = '0;
        high_n   = '0;
        if (rise) begin
          period_n  = CNT_W'(1);
          high_n    = CNT_W'(1);
          stuck_n   = 1'b0;
          m_state_n = M_RUN;
        end
      end
      M_RUN: begin
        if (rise) begin
          period_n = CNT_W'(1);
          high_n   = CNT_W'(1);
          if (div_busy) ovr_n = 1'b1;
          else          start = 1'b1;
        end else if (period_cnt == CNT_MAX) begin
          m_state_n = M_WAIT_FIRST;
          period_n  = '0;
          high_n    = '0;
          stuck_n   = 1'b1;
          tmo_n     = 1'b1;
          duty_n    = pwm_sync ? DUTY_W'(DUTY_SCALE) : '0;
        end else begin
          period_n = period_cnt + CNT_W'(1);
          high_n   = high_cnt + CNT_W'(pwm_sync);
        end
      end
      default: m_state_n = M_WAIT_FIRST;
    endcase
  end

  always_ff @(posedge sysclk or posedge i_rst) begin
    if (i_rst) begin
      m_state    <= M_WAIT_FIRST;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_hold  <= '0;
      stuck_q    <= 1'b0;
      tmo_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      m_state    <= m_state_n;
      period_cnt <= period_n;
      high_cnt   <= high_n;
      duty_hold  <= duty_n;
      stuck_q    <= stuck_n;
      tmo_q      <= tmo_n;
      ovr_q      <= ovr_n;
    end
  end

  pwm_seq_div #(.N_W(NUM_W), .D_W(CNT_W), .Q_W(DUTY_W)) u_div (
    .clk   (sysclk),
    .rst   (i_rst),
    .start (start),
    .num   (num),
    .den   (period_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Result is presented in the divider's D_DONE cycle straight from its quotient register.
  assign bus.o_duty    = div_done ? div_quot : duty_hold;
  assign bus.o_valid   = div_done | tmo_q;
  assign bus.o_stuck   = stuck_q;
  assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: table vectors, stuck/reset corner sequences, random PWM vs period model.
module tb_pwm_duty_meter;
  import pwm_meter_pkg::*;

  localparam int CW  = 10;
  localparam int LAT = CW + 11;
  localparam int TMO = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pwm_duty_meter_if ifc();

  pwm_duty_meter #(.CNT_W(CW)) dut (.sysclk(clk), .i_rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a result per accepted rise, computed from rise times and high lengths.
  typedef struct {int duty; int at;} res_t;
  res_t exp_q[$];
  int   exp_ovr, obs_ovr, n_valid, acc_cnt;
  int   prev_rise, last_acc, pend_high;
  bit   have_prev, have_acc, mon_en;
  int   last_valid_cyc, last_valid_duty;

  task automatic model_reset();
    exp_q.delete();
    have_prev = 0; have_acc = 0;
    exp_ovr = 0; obs_ovr = 0; n_valid = 0; acc_cnt = 0;
  endtask

  task automatic model_rise(input int t, input int h);
    res_t r;
    if (have_prev) begin
      if (!have_acc || (t - last_acc) >= LAT) begin
        r.duty = pend_high * DUTY_SCALE / (t - prev_rise);
        r.at   = t + 2 + LAT;
        exp_q.push_back(r);
        last_acc = t; have_acc = 1; acc_cnt++;
      end else begin
        exp_ovr++;
      end
    end
    have_prev = 1; prev_rise = cyc; pend_high = h;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.o_overrun) obs_ovr++;
      if (ifc.o_valid) begin
        res_t r;
        n_valid++;
        last_valid_cyc  = cyc;
        last_valid_duty = int'(ifc.o_duty);
        if (mon_en) begin
          chk("valid_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("duty", ifc.o_duty, r.duty);
            chk("valid_cycle", cyc, r.at);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ifc.i_pwm = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
    repeat (5) step();
  endtask

  task automatic drive_period(input int h, input int l);
    model_rise(cyc, h);
    ifc.i_pwm = 1'b1;
    repeat (h) step();
    ifc.i_pwm = 1'b0;
    repeat (l) step();
  endtask

  task automatic final_rise();
    model_rise(cyc, 1);
    ifc.i_pwm = 1'b1;
  endtask

  task automatic finish_scn(input string name);
    repeat (LAT + 5) step();
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_overrun"}, obs_ovr, exp_ovr);
    chk({name, "_count"}, n_valid, acc_cnt);
  endtask

  typedef struct {int high; int low; int duty;} vec_t;
  vec_t tbl[8];

  initial begin
    int t;
    tbl[0] = '{100, 300, 250};
    tbl[1] = '{50,  50,  500};
    tbl[2] = '{7,   14,  333};
    tbl[3] = '{1,   20,  47};
    tbl[4] = '{20,  1,   952};
    tbl[5] = '{333, 667, 333};
    tbl[6] = '{999, 23,  977};
    tbl[7] = '{1,   1022, 0};

    ifc.i_pwm = 1'b0;
    mon_en = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_duty", ifc.o_duty, 0);
    chk("rst_valid", ifc.o_valid, 0);
    chk("rst_stuck", ifc.o_stuck, 0);
    chk("rst_overrun", ifc.o_overrun, 0);

    // table vectors: three captured periods each
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < 3; k++) drive_period(tbl[i].high, tbl[i].low);
      final_rise();
      finish_scn($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_duty", i), last_valid_duty, tbl[i].duty);
      chk($sformatf("tbl%0d_stuck", i), ifc.o_stuck, 0);
    end

    // period 3, one high: alternate results dropped with overrun
    do_reset();
    for (int k = 0; k < 40; k++) drive_period(1, 2);
    final_rise();
    finish_scn("p3");
    chk("p3_duty", last_valid_duty, 333);
    chk("p3_overrun_seen", obs_ovr > 0, 1);

    // held high after one rise: timeout with duty 1000, then recovery
    do_reset();
    mon_en = 1'b0;
    t = cyc;
    ifc.i_pwm = 1'b1;
    for (int k = 0; k < TMO + 20 && n_valid == 0; k++) step();
    chk("hi_stuck_valids", n_valid, 1);
    chk("hi_stuck_cycle", last_valid_cyc, t + 2 + TMO + 1);
    chk("hi_stuck_duty", last_valid_duty, 1000);
    chk("hi_stuck_flag", ifc.o_stuck, 1);
    repeat (20) step();
    chk("hi_stuck_single", n_valid, 1);
    chk("hi_stuck_hold", ifc.o_duty, 1000);
    model_reset();
    mon_en = 1'b1;
    ifc.i_pwm = 1'b0;
    repeat (10) step();
    model_rise(cyc, 30);
    ifc.i_pwm = 1'b1;
    repeat (4) step();
    chk("hi_stuck_clear", ifc.o_stuck, 0);
    repeat (26) step();
    ifc.i_pwm = 1'b0;
    repeat (30) step();
    drive_period(30, 30);
    final_rise();
    finish_scn("recover");
    chk("recover_duty", last_valid_duty, 500);

    // held low: no rise keeps everything quiet; one pulse then timeout to 0
    do_reset();
    mon_en = 1'b0;
    repeat (TMO + 50) step();
    chk("lo_nostuck", ifc.o_stuck, 0);
    chk("lo_noduty", ifc.o_duty, 0);
    chk("lo_novalid", n_valid, 0);
    t = cyc;
    ifc.i_pwm = 1'b1;
    repeat (5) step();
    ifc.i_pwm = 1'b0;
    for (int k = 0; k < TMO + 20 && n_valid == 0; k++) step();
    chk("lo_stuck_valids", n_valid, 1);
    chk("lo_stuck_cycle", last_valid_cyc, t + 2 + TMO + 1);
    chk("lo_stuck_duty", last_valid_duty, 0);
    chk("lo_stuck_flag", ifc.o_stuck, 1);

    // reset 15 cycles into a division
    do_reset();
    mon_en = 1'b0;
    drive_period(25, 75);
    ifc.i_pwm = 1'b1;
    repeat (17) step();
    rst = 1'b1;
    step();
    chk("midrst_duty", ifc.o_duty, 0);
    chk("midrst_stuck", ifc.o_stuck, 0);
    rst = 1'b0;
    ifc.i_pwm = 1'b0;
    repeat (40) step();
    chk("midrst_novalid", n_valid, 0);
    chk("midrst_duty_after", ifc.o_duty, 0);
    model_reset();
    mon_en = 1'b1;
    drive_period(25, 75);
    drive_period(25, 75);
    final_rise();
    finish_scn("midrst_restart");
    chk("midrst_restart_duty", last_valid_duty, 250);

    // random periods, including short ones that overrun
    do_reset();
    for (int k = 0; k < 60; k++) begin
      int p, h;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : int'($urandom_range(21, 250));
      h = int'($urandom_range(1, p - 1));
      drive_period(h, p - h);
    end
    final_rise();
    finish_scn("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
